bus_dma_master: RTL and testbench
=================================

# bus_dma_master

Word-copy DMA engine acting as a bus initiator on the data bus. It moves a block of 32-bit words from a source to a destination address by issuing read and write cycles on the same enable/write_enable/Address/din/dout interface the data-memory bus decodes. It sits beside the CPU as a second bus master and obtains the bus through a simple request/grant handshake. Software-visible completion is signalled by a one-cycle done pulse and a sticky error flag.

## Interface
Parameters:
- READ_LATENCY, 0: bus read-data latency in cycles. 0 means dout is valid in the same cycle as the read access. 1 means dout is valid one cycle later. Only 0 and 1 are legal.
- MEM_LIMIT, 32'h40000000: first unmapped address. Any access at or above it is an error.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a transfer; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] are ignored (forced 0)
- dst_addr  in  32  destination byte address; bits [1:0] are ignored
- word_count  in  16  number of words to copy; 0 is legal
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse at the end of a transfer, both normal and error completion
- error  out  1  set on an out-of-range access; held until the next accepted start or reset
- bus_req  out  1  bus request, high whenever the state is READ, RWAIT or WRITE
- bus_gnt  in  1  bus grant from the arbiter
- bus_enable  out  1  access strobe to the bus
- bus_write_enable  out  1  write strobe; only ever high together with bus_enable
- bus_address  out  32  access address; 0 whenever bus_enable=0
- bus_wdata  out  32  write data; 0 whenever bus_write_enable=0
- bus_rdata  in  32  read data from the bus

## Operation
States: IDLE, READ, RWAIT (exists only when READ_LATENCY=1), WRITE, DONE.

- **IDLE**
  - On start=1: latch src, dst (low 2 bits cleared) and remaining=word_count, and clear error.
  - If word_count=0, go to DONE. Otherwise go to READ.
- **READ**
  - If src >= MEM_LIMIT: set error, go to DONE, and issue no access.
  - Else if bus_gnt=1: drive bus_enable=1, bus_write_enable=0, bus_address=src.
    - READ_LATENCY=0: capture bus_rdata into the data buffer at the clock edge, then go to WRITE.
    - READ_LATENCY=1: go to RWAIT.
  - Else (bus_gnt=0): stall with all bus strobes 0.
- **RWAIT**
  - Strobes are 0.
  - Capture bus_rdata into the buffer, then go to WRITE. bus_gnt is not checked in this state.
- **WRITE**
  - If dst >= MEM_LIMIT: set error, go to DONE, and issue no access.
  - Else if bus_gnt=1: drive bus_enable=1, bus_write_enable=1, bus_address=dst, bus_wdata=buffer.
    - At the edge: src+=4, dst+=4, remaining-=1.
    - Go to DONE if remaining was 1, else go to READ.
  - Else (bus_gnt=0): stall with strobes 0. The buffer is held.
- **DONE**
  - done=1 for this single cycle, then go to IDLE.

Other rules:
- start asserted outside IDLE is ignored. It is not queued.
- Address arithmetic is modulo 2^32. An address that wraps past 0xFFFFFFFC to 0 is caught by the MEM_LIMIT check before it wraps, so no wrapped access is ever issued.
- bus_gnt dropping mid-transfer only stalls the engine. No access is repeated or skipped.
- Reset in any state:
  - Next cycle the state is IDLE and every output is 0, including error.
  - Words already written stay written. The engine never resumes the interrupted transfer.

## Timing
- Reset values: busy=0, done=0, error=0, bus_req=0, bus_enable=0, bus_write_enable=0, bus_address=0, bus_wdata=0.
- All outputs are registered-state decodes: no combinational path from bus_rdata to any output. The bus_gnt to strobe path may be combinational.
- With bus_gnt held at 1:
  - Start is accepted at edge 0.
  - Word k (0-based) is read in cycle 1+k*(2+READ_LATENCY).
  - Word k is written in cycle 2+READ_LATENCY+k*(2+READ_LATENCY).
  - The done cycle is N*(2+READ_LATENCY)+1.
- word_count=0: done is asserted in cycle 1, busy=1 for that cycle only, and no bus access occurs.
- Each cycle with bus_gnt=0 in READ or WRITE adds exactly one cycle to the total.
- A new start is accepted in the first IDLE cycle after DONE.

## Test plan
- **Basic copy:** memory[0x100..0x10C] = 0xA0..0xA3. start with src=0x100, dst=0x200, count=4, READ_LATENCY=0, gnt=1.
  - Required: memory[0x200..0x20C] = 0xA0..0xA3.
  - Required: done pulses in cycle 9; exactly 8 bus accesses occur.
- **Zero count:** count=0.
  - Required: done in cycle 1, bus_enable never high, error=0.
- **Grant stall:** count=2. Drop gnt for 3 cycles during the first WRITE.
  - Required: data is correct, done in cycle 8, and bus_enable is low during every stall cycle.
- **Error path:** src=0x3FFFFFFC, dst=0x100, count=3.
  - Required: the first word is copied, then error=1 with done, and there is no access at 0x40000000.
  - Required: error clears on the next start.
- **READ_LATENCY=1 plus start while busy:** count=2, with a second start pulse in cycle 3.
  - Required: the second start is ignored, the data is correct, and done is in cycle 7.
- **Reset mid-transfer:** count=8. Assert reset in cycle 5.
  - Required: all outputs are 0 in cycle 6, words 0-1 are written, and word 2 onward are untouched.

Source files
------------

// File: rtl/bus_dma_master.sv
// rtl/bus_dma_master.sv - word-copy DMA engine acting as a second data-bus master
// Reads one word, writes it, and repeats; the bus is held only while gnt is high.
module bus_dma_master #(
  parameter int          READ_LATENCY = 0,
  parameter logic [31:0] MEM_LIMIT    = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_enable,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_RWAIT = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  // Bit 32 records a carry out of the 32-bit address so a wrapped pointer
  // still compares as out of range instead of restarting at zero.
  logic [32:0] src_q, src_d;
  logic [32:0] dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] buf_q, buf_d;
  logic        err_q, err_d;

  logic src_oob, dst_oob;
  logic rd_acc, wr_acc;

  assign src_oob = (src_q >= {1'b0, MEM_LIMIT});
  assign dst_oob = (dst_q >= {1'b0, MEM_LIMIT});

  assign rd_acc = (state_q == ST_READ)  && !src_oob && bus_gnt;
  assign wr_acc = (state_q == ST_WRITE) && !dst_oob && bus_gnt;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = {1'b0, src_addr & 32'hFFFF_FFFC};
          dst_d   = {1'b0, dst_addr & 32'hFFFF_FFFC};
          rem_d   = word_count;
          err_d   = 1'b0;
          state_d = (word_count == 16'd0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (src_oob) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (bus_gnt) begin
          if (READ_LATENCY == 0) begin
            buf_d   = bus_rdata;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        buf_d   = bus_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (dst_oob) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (bus_gnt) begin
          src_d   = src_q + 33'd4;
          dst_d   = dst_q + 33'd4;
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= 33'd0;
      dst_q   <= 33'd0;
      rem_q   <= 16'd0;
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign error            = err_q;
  assign bus_req          = (state_q == ST_READ) || (state_q == ST_RWAIT) || (state_q == ST_WRITE);
  assign bus_enable       = rd_acc || wr_acc;
  assign bus_write_enable = wr_acc;
  assign bus_address      = rd_acc ? src_q[31:0] : (wr_acc ? dst_q[31:0] : 32'd0);
  assign bus_wdata        = wr_acc ? buf_q : 32'd0;

endmodule

// File: tb/tb_bus_dma_master.sv
// tb/tb_bus_dma_master.sv - randomized self-checking bench for bus_dma_master
// Instance 0 uses READ_LATENCY=0, instance 1 uses READ_LATENCY=1; one is active at a time.
module tb_bus_dma_master;

  localparam longint LIM  = 64'h4000_0000;
  localparam int     MAXC = 400;
  localparam int     NONE = 1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s [2];
  logic        start_s [2];
  logic [31:0] src_s   [2];
  logic [31:0] dst_s   [2];
  logic [15:0] cnt_s   [2];
  logic        gnt_s   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic        req_o   [2];
  logic        en_o    [2];
  logic        we_o    [2];
  logic [31:0] addr_o  [2];
  logic [31:0] wd_o    [2];
  logic [31:0] rdata0, rdata1;

  bus_dma_master #(.READ_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .src_addr(src_s[0]),
    .dst_addr(dst_s[0]), .word_count(cnt_s[0]), .busy(busy_o[0]), .done(done_o[0]),
    .error(err_o[0]), .bus_req(req_o[0]), .bus_gnt(gnt_s[0]), .bus_enable(en_o[0]),
    .bus_write_enable(we_o[0]), .bus_address(addr_o[0]), .bus_wdata(wd_o[0]),
    .bus_rdata(rdata0)
  );

  bus_dma_master #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .src_addr(src_s[1]),
    .dst_addr(dst_s[1]), .word_count(cnt_s[1]), .busy(busy_o[1]), .done(done_o[1]),
    .error(err_o[1]), .bus_req(req_o[1]), .bus_gnt(gnt_s[1]), .bus_enable(en_o[1]),
    .bus_write_enable(we_o[1]), .bus_address(addr_o[1]), .bus_wdata(wd_o[1]),
    .bus_rdata(rdata1)
  );

  // Memory seen by the DUTs and the model's image of what it must become; key = {instance, address}.
  logic [31:0] mem  [logic [32:0]];
  logic [31:0] emem [logic [32:0]];

  bit          gsched [MAXC];
  bit          x_en   [MAXC];
  bit          x_we   [MAXC];
  logic [31:0] x_a    [MAXC];
  logic [31:0] x_d    [MAXC];
  int          done_c, abort_c, cyc, act;
  bit          x_err, chk_on;
  bit          prev_err [2];
  int          n_chk, n_fail;

  logic        cap_en [2];
  logic        cap_we [2];
  logic [31:0] cap_a  [2];
  logic [31:0] cap_d  [2];

  function automatic logic [32:0] key(input int inst, input logic [31:0] a);
    return {inst[0], a};
  endfunction

  function automatic logic [31:0] init_val(input logic [32:0] k);
    return (k[31:0] * 32'h9E37_79B9) + {31'd0, k[32]};
  endfunction

  function automatic logic [31:0] mrd(input logic [32:0] k);
    if (mem.exists(k)) return mem[k];
    return init_val(k);
  endfunction

  function automatic logic [31:0] erd(input logic [32:0] k);
    if (emem.exists(k)) return emem[k];
    return init_val(k);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, act, cyc, got, want);
    end
  endtask

  task automatic poke(input int inst, input logic [31:0] a, input logic [31:0] v);
    mem[key(inst, a)]  = v;
    emem[key(inst, a)] = v;
  endtask

  // Bus slave: sample the access mid-cycle, commit writes at the edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cap_en[i] = en_o[i];
      cap_we[i] = we_o[i];
      cap_a[i]  = addr_o[i];
      cap_d[i]  = wd_o[i];
    end
    rdata0 = (en_o[0] && !we_o[0]) ? mrd(key(0, addr_o[0])) : (32'hBAD0_0000 ^ $urandom);
  end

  always @(posedge clk) begin
    logic [31:0] nxt;
    for (int i = 0; i < 2; i++)
      if (cap_en[i] && cap_we[i]) mem[key(i, cap_a[i])] = cap_d[i];
    nxt = (cap_en[1] && !cap_we[1]) ? mrd(key(1, cap_a[1])) : (32'hBAD1_0000 ^ $urandom);
    #1 rdata1 = nxt;
  end

  always @(negedge clk) begin : cmp
    logic e_en, e_we, e_done, e_busy, e_req, e_err;
    logic [31:0] e_a, e_d;
    int oth;
    if (chk_on) begin
      if (cyc > abort_c) begin
        e_en = 0; e_we = 0; e_done = 0; e_busy = 0; e_req = 0; e_err = 0;
        e_a = 0; e_d = 0;
      end else begin
        e_en   = x_en[cyc];
        e_we   = x_we[cyc];
        e_a    = x_en[cyc] ? x_a[cyc] : 32'd0;
        e_d    = x_we[cyc] ? x_d[cyc] : 32'd0;
        e_done = (cyc == done_c);
        e_busy = (cyc >= 1) && (cyc <= done_c);
        e_req  = (cyc >= 1) && (cyc < done_c);
        e_err  = (cyc == 0) ? prev_err[act] : ((cyc >= done_c) ? x_err : 1'b0);
      end
      check("busy", 32'(busy_o[act]), 32'(e_busy));
      check("done", 32'(done_o[act]), 32'(e_done));
      check("error", 32'(err_o[act]), 32'(e_err));
      check("bus_req", 32'(req_o[act]), 32'(e_req));
      check("bus_enable", 32'(en_o[act]), 32'(e_en));
      check("bus_write_enable", 32'(we_o[act]), 32'(e_we));
      check("bus_address", addr_o[act], e_a);
      check("bus_wdata", wd_o[act], e_d);
      oth = 1 - act;
      check("idle_inst_enable", 32'(en_o[oth]), 32'd0);
      check("idle_inst_busy", 32'(busy_o[oth]), 32'd0);
    end
  end

  // Transaction-level model: walk the words in order, spending one cycle per
  // grant-less cycle, 1+latency per read, 1 per write and 1 for a range error.
  task automatic xfer(input int inst, input logic [31:0] s, input logic [31:0] d, input int n,
                      input int abort_at, input int s2_in, input int pad);
    longint sa, da, a;
    int c, last, s2, lat;
    logic [31:0] v;
    @(posedge clk);
    #1;
    lat = inst;
    for (int i = 0; i < MAXC; i++) begin
      x_en[i] = 0; x_we[i] = 0; x_a[i] = 0; x_d[i] = 0;
    end
    x_err = 0;
    sa = longint'(s & 32'hFFFF_FFFC);
    da = longint'(d & 32'hFFFF_FFFC);
    c = 1;
    for (int k = 0; k < n; k++) begin
      a = sa + 4 * k;
      if (a >= LIM) begin x_err = 1; c++; break; end
      while (!gsched[c]) c++;
      x_en[c] = 1; x_a[c] = a[31:0];
      v = erd(key(inst, a[31:0]));
      c += 1 + lat;
      a = da + 4 * k;
      if (a >= LIM) begin x_err = 1; c++; break; end
      while (!gsched[c]) c++;
      x_en[c] = 1; x_we[c] = 1; x_a[c] = a[31:0]; x_d[c] = v;
      if (c <= abort_at) emem[key(inst, a[31:0])] = v;
      c++;
    end
    done_c = c;
    s2   = (s2_in > done_c) ? -1 : s2_in;
    last = (abort_at < NONE) ? abort_at + 1 + pad : done_c + pad;
    if (last >= MAXC) begin
      n_chk++; n_fail++;
      $display("FAIL cycle_budget got=%0d want<%0d", last, MAXC);
      last = MAXC - 1;
    end
    act = inst; abort_c = abort_at; cyc = 0; chk_on = 1;
    start_s[inst] = 1; src_s[inst] = s; dst_s[inst] = d; cnt_s[inst] = 16'(n);
    gnt_s[inst] = gsched[0]; reset_s[inst] = 0;
    for (int cc = 1; cc <= last; cc++) begin
      @(posedge clk);
      #1;
      cyc = cc;
      start_s[inst] = (cc == s2);
      reset_s[inst] = (cc == abort_at);
      gnt_s[inst]   = gsched[cc];
    end
    start_s[inst] = 0;
    reset_s[inst] = 0;
    prev_err[inst] = (abort_at < NONE) ? 1'b0 : x_err;
  endtask

  task automatic all_gnt();
    for (int i = 0; i < MAXC; i++) gsched[i] = 1;
  endtask

  function automatic int n_acc();
    int t = 0;
    for (int i = 0; i < MAXC; i++) t += int'(x_en[i]);
    return t;
  endfunction

  initial begin
    logic [31:0] rs, rd;
    n_chk = 0; n_fail = 0; chk_on = 0; abort_c = NONE; cyc = 0; act = 0; done_c = 0;
    for (int i = 0; i < 2; i++) begin
      reset_s[i] = 1; start_s[i] = 0; src_s[i] = 0; dst_s[i] = 0; cnt_s[i] = 0; gnt_s[i] = 0;
      prev_err[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      act = i;
      check("rst_busy", 32'(busy_o[i]), 32'd0);
      check("rst_done", 32'(done_o[i]), 32'd0);
      check("rst_error", 32'(err_o[i]), 32'd0);
      check("rst_req", 32'(req_o[i]), 32'd0);
      check("rst_enable", 32'(en_o[i]), 32'd0);
      check("rst_we", 32'(we_o[i]), 32'd0);
      check("rst_addr", addr_o[i], 32'd0);
      check("rst_wdata", wd_o[i], 32'd0);
    end
    reset_s[0] = 0; reset_s[1] = 0;

    // Basic copy
    for (int i = 0; i < 4; i++) poke(0, 32'h100 + 4 * i, 32'hA0 + i);
    all_gnt();
    xfer(0, 32'h100, 32'h200, 4, NONE, -1, 1);
    check("basic_done_cycle", done_c, 9);
    check("basic_accesses", n_acc(), 8);
    for (int i = 0; i < 4; i++) check("basic_data", mrd(key(0, 32'h200 + 4 * i)), 32'hA0 + i);

    // Zero count, immediately followed by the next start
    xfer(0, 32'h300, 32'h400, 0, NONE, -1, 0);
    check("zero_done_cycle", done_c, 1);
    check("zero_accesses", n_acc(), 0);

    // Grant dropped for three cycles during the first write
    poke(0, 32'h500, 32'h5555_0001);
    poke(0, 32'h504, 32'h5555_0002);
    for (int i = 2; i <= 4; i++) gsched[i] = 0;
    xfer(0, 32'h500, 32'h600, 2, NONE, -1, 1);
    check("stall_done_cycle", done_c, 8);
    check("stall_data0", mrd(key(0, 32'h600)), 32'h5555_0001);
    check("stall_data1", mrd(key(0, 32'h604)), 32'h5555_0002);

    // Source runs into MEM_LIMIT after one word
    all_gnt();
    poke(0, 32'h3FFF_FFFC, 32'h1234_5678);
    xfer(0, 32'h3FFF_FFFC, 32'h100, 3, NONE, -1, 1);
    check("err_done_cycle", done_c, 4);
    check("err_flag_model", 32'(x_err), 32'd1);
    check("err_first_word", mrd(key(0, 32'h100)), 32'h1234_5678);
    check("err_held", 32'(err_o[0]), 32'd1);
    xfer(0, 32'h700, 32'h800, 1, NONE, -1, 0);
    check("err_cleared", 32'(err_o[0]), 32'd0);

    // READ_LATENCY=1 with a start pulse while busy
    poke(1, 32'h100, 32'hC0DE_0000);
    poke(1, 32'h104, 32'hC0DE_0001);
    xfer(1, 32'h100, 32'h200, 2, NONE, 3, 1);
    check("lat1_done_cycle", done_c, 7);
    check("lat1_data0", mrd(key(1, 32'h200)), 32'hC0DE_0000);
    check("lat1_data1", mrd(key(1, 32'h204)), 32'hC0DE_0001);

    // Reset during the read of word 2
    xfer(0, 32'h900, 32'hA00, 8, 5, -1, 1);
    check("rst_word0", mrd(key(0, 32'hA00)), init_val(key(0, 32'h900)));
    check("rst_word1", mrd(key(0, 32'hA04)), init_val(key(0, 32'h904)));
    check("rst_word2_untouched", 32'(mem.exists(key(0, 32'hA08))), 32'd0);

    // Randomized transfers on both instances
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < MAXC; i++) gsched[i] = (i >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 5) == 0) ? (32'h4000_0000 - 4 * $urandom_range(0, 5))
                                       : (32'h1000 + 4 * $urandom_range(0, 48));
      rd = ($urandom_range(0, 5) == 0) ? (32'h4000_0000 - 4 * $urandom_range(0, 5))
                                       : (32'h1000 + 4 * $urandom_range(0, 48));
      rs = rs + $urandom_range(0, 3);
      rd = rd + $urandom_range(0, 3);
      xfer(t % 2, rs, rd, $urandom_range(0, 10), NONE,
           ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : -1, $urandom_range(0, 2));
    end
    @(posedge clk);
    #1;
    chk_on = 0;
    for (int i = 0; i < 2; i++)
      foreach (emem[k]) if (k[32] == i[0]) check("final_mem", mrd(k), emem[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
